// File: rtl/id_stage.sv
// id_stage: IF/ID register, 64x32 register file with writeback bypass,
// control decode and load-use hazard detection feeding the ID/EX register.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcIn,
    input  logic        flush,
    input  logic        exMemRead,
    input  logic [5:0]  exRd,
    input  logic        wbRegWrt,
    input  logic [5:0]  wbRd,
    input  logic [31:0] wbData,
    output logic        stall,
    output logic        RegWrtOut,
    output logic        memToRegOut,
    output logic        PCtoRegOut,
    output logic        BranchNOut,
    output logic        BranchZOut,
    output logic        JumpOut,
    output logic        JumpMemOut,
    output logic        memReadOut,
    output logic        memWriteOut,
    output logic        immeOut,
    output logic [1:0]  ALUopOut,
    output logic [31:0] XrsOut,
    output logic [31:0] XrtOut,
    output logic [31:0] Yout,
    output logic [31:0] PC_YOut,
    output logic [5:0]  rdOut
);
    logic [31:0] if_instr_q, if_instr_d, if_pc_q, if_pc_d;
    logic [31:0] rf_q [64];
    logic [3:0]  op;
    logic [5:0]  rs, rt;
    logic [11:0] ctl;
    logic        rs_used, rt_used;

    assign op = if_instr_q[31:28];
    assign rs = if_instr_q[21:16];
    assign rt = if_instr_q[15:10];

    // ctl = {RegWrt, memToReg, PCtoReg, BranchN, BranchZ, Jump, JumpMem, memRead, memWrite, imme, ALUop}
    always_comb begin
        ctl     = '0;
        rs_used = 1'b0;
        rt_used = 1'b0;
        case (op)
            4'b1111: ctl = 12'hA00;
            4'b1110: begin ctl = 12'hC13; rs_used = 1'b1; end
            4'b0011: begin ctl = 12'h00B; rs_used = 1'b1; rt_used = 1'b1; end
            4'b0100: begin ctl = 12'h800; rs_used = 1'b1; rt_used = 1'b1; end
            4'b0101: begin ctl = 12'h804; rs_used = 1'b1; end
            4'b0110: begin ctl = 12'h802; rs_used = 1'b1; end
            4'b0111: begin ctl = 12'h801; rs_used = 1'b1; rt_used = 1'b1; end
            4'b1000: begin ctl = 12'h040; rs_used = 1'b1; end
            4'b1001: begin ctl = 12'h080; rs_used = 1'b1; end
            4'b1010: begin ctl = 12'h030; rs_used = 1'b1; end
            4'b1011: begin ctl = 12'h100; rs_used = 1'b1; end
            default: ctl = '0;
        endcase
    end

    assign stall = exMemRead && ((exRd == rs && rs_used) || (exRd == rt && rt_used));

    // A stalled instruction leaves a bubble: controls cleared, data left intact.
    assign {RegWrtOut, memToRegOut, PCtoRegOut, BranchNOut, BranchZOut, JumpOut,
            JumpMemOut, memReadOut, memWriteOut, immeOut, ALUopOut} = stall ? 12'h000 : ctl;

    assign XrsOut  = (wbRegWrt && wbRd == rs) ? wbData : rf_q[rs];
    assign XrtOut  = (wbRegWrt && wbRd == rt) ? wbData : rf_q[rt];
    assign Yout    = {{16{if_instr_q[15]}}, if_instr_q[15:0]};
    assign PC_YOut = if_pc_q + Yout;
    assign rdOut   = if_instr_q[27:22];

    assign if_instr_d = flush ? 32'h0 : stall ? if_instr_q : instrIn;
    assign if_pc_d    = flush ? 32'h0 : stall ? if_pc_q : pcIn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) rf_q[i] <= '0;
        end else if (wbRegWrt) begin
            rf_q[wbRd] <= wbData;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors with hand-computed expectations for id_stage.
module tb_id_stage;
    logic        clk, rst, flush, exMemRead, wbRegWrt;
    logic [31:0] instrIn, pcIn, wbData;
    logic [5:0]  exRd, wbRd;
    logic        stall, RegWrtOut, memToRegOut, PCtoRegOut, BranchNOut, BranchZOut;
    logic        JumpOut, JumpMemOut, memReadOut, memWriteOut, immeOut;
    logic [1:0]  ALUopOut;
    logic [31:0] XrsOut, XrtOut, Yout, PC_YOut;
    logic [5:0]  rdOut;
    logic [11:0] ctl;
    int          n_cmp = 0, n_bad = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .instrIn(instrIn), .pcIn(pcIn), .flush(flush),
        .exMemRead(exMemRead), .exRd(exRd), .wbRegWrt(wbRegWrt), .wbRd(wbRd),
        .wbData(wbData), .stall(stall), .RegWrtOut(RegWrtOut), .memToRegOut(memToRegOut),
        .PCtoRegOut(PCtoRegOut), .BranchNOut(BranchNOut), .BranchZOut(BranchZOut),
        .JumpOut(JumpOut), .JumpMemOut(JumpMemOut), .memReadOut(memReadOut),
        .memWriteOut(memWriteOut), .immeOut(immeOut), .ALUopOut(ALUopOut),
        .XrsOut(XrsOut), .XrtOut(XrtOut), .Yout(Yout), .PC_YOut(PC_YOut), .rdOut(rdOut)
    );

    assign ctl = {RegWrtOut, memToRegOut, PCtoRegOut, BranchNOut, BranchZOut, JumpOut,
                  JumpMemOut, memReadOut, memWriteOut, immeOut, ALUopOut};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] o, input logic [5:0] d,
                                       input logic [5:0] s, input logic [5:0] t);
        return {o, d, s, t, 10'h0};
    endfunction

    logic [3:0]  dec_op  [8] = '{4'hF, 4'hE, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'h1};
    logic [11:0] dec_ctl [8] = '{12'hA00, 12'hC13, 12'h00B, 12'h040, 12'h080, 12'h030, 12'h100, 12'h000};

    initial begin
        rst = 1'b1; flush = 1'b0; exMemRead = 1'b0; wbRegWrt = 1'b0;
        instrIn = '0; pcIn = '0; wbData = '0; exRd = '0; wbRd = '0;
        #1;
        chk("rst_ctl", ctl, 0);
        chk("rst_stall", stall, 0);
        chk("rst_pcy", PC_YOut, 0);
        cyc();
        rst = 1'b0;
        wbRegWrt = 1'b1; wbRd = 6'd2; wbData = 32'd7;
        cyc();
        wbRd = 6'd3; wbData = 32'd5;
        cyc();
        wbRegWrt = 1'b0;
        // ADD r1 = r2 + r3
        instrIn = mk(4'h4, 6'd1, 6'd2, 6'd3); pcIn = 32'h4;
        cyc();
        chk("add_ctl", ctl, 12'h800);
        chk("add_xrs", XrsOut, 7);
        chk("add_xrt", XrtOut, 5);
        chk("add_rd", rdOut, 1);
        chk("add_y", Yout, 32'h0C00);
        chk("add_pcy", PC_YOut, 32'h0C04);
        // INC with negative immediate
        instrIn = {4'h5, 6'd2, 6'd3, 16'hFFFE}; pcIn = 32'h10;
        cyc();
        chk("inc_ctl", ctl, 12'h804);
        chk("inc_y", Yout, 32'hFFFFFFFE);
        chk("inc_pcy", PC_YOut, 32'h0000000E);
        chk("inc_xrs", XrsOut, 5);
        // load-use on rs
        exMemRead = 1'b1; exRd = 6'd4;
        instrIn = mk(4'h4, 6'd5, 6'd4, 6'd1); pcIn = 32'h20;
        cyc();
        chk("lu_stall", stall, 1);
        chk("lu_ctl", ctl, 0);
        chk("lu_rd", rdOut, 5);
        instrIn = mk(4'h6, 6'd6, 6'd7, 6'd4); pcIn = 32'h30;
        cyc();
        chk("lu_hold_stall", stall, 1);
        chk("lu_hold_pcy", PC_YOut, 32'h420);
        exMemRead = 1'b0;
        #1;
        chk("lu_rel_stall", stall, 0);
        chk("lu_rel_ctl", ctl, 12'h800);
        chk("lu_rel_rd", rdOut, 5);
        cyc();
        chk("neg_ctl", ctl, 12'h802);
        exMemRead = 1'b1; exRd = 6'd4;
        #1;
        chk("neg_rt_unused", stall, 0);
        // load-use on rt
        exRd = 6'd3;
        instrIn = mk(4'h7, 6'd1, 6'd2, 6'd3); pcIn = 32'h40;
        cyc();
        chk("rt_stall", stall, 1);
        chk("rt_ctl", ctl, 0);
        // flush over stall, writeback on the same edge
        flush = 1'b1; wbRegWrt = 1'b1; wbRd = 6'd9; wbData = 32'h1234;
        cyc();
        flush = 1'b0; wbRegWrt = 1'b0; exMemRead = 1'b0;
        #1;
        chk("fl_stall", stall, 0);
        chk("fl_ctl", ctl, 0);
        chk("fl_rd", rdOut, 0);
        chk("fl_pcy", PC_YOut, 0);
        // bypass
        instrIn = mk(4'h4, 6'd0, 6'd9, 6'd2); pcIn = 32'h50;
        cyc();
        chk("fl_wb_xrs", XrsOut, 32'h1234);
        chk("byp_xrt", XrtOut, 7);
        wbRegWrt = 1'b1; wbRd = 6'd9; wbData = 32'hDEADBEEF;
        #1;
        chk("byp_xrs", XrsOut, 32'hDEADBEEF);
        wbRegWrt = 1'b0;
        #1;
        chk("byp_nowr", XrsOut, 32'h1234);
        // remaining opcodes, plus an undefined one
        for (int i = 0; i < 8; i++) begin
            instrIn = {dec_op[i], 6'd8, 6'd9, 16'h0};
            cyc();
            chk($sformatf("dec_%h", dec_op[i]), ctl, dec_ctl[i]);
        end
        // reset mid-run
        wbRegWrt = 1'b1; wbRd = 6'd5; wbData = 32'h55;
        instrIn = mk(4'h4, 6'd1, 6'd5, 6'd2); pcIn = 32'h60;
        cyc();
        wbRegWrt = 1'b0;
        #1;
        chk("pre_rst_xrs", XrsOut, 32'h55);
        rst = 1'b1;
        #1;
        chk("mrst_ctl", ctl, 0);
        chk("mrst_xrs", XrsOut, 0);
        chk("mrst_rd", rdOut, 0);
        chk("mrst_y", Yout, 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_ctl", ctl, 12'h800);
        chk("post_rst_r5", XrsOut, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
